// File: rtl/ram_stream_reader.sv
// Streams a range of words out of a registered-read RAM onto a valid/ready
// interface, absorbing the one-cycle read latency with a 2-entry output FIFO.
module ram_stream_reader #(
  parameter int SIZE  = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [AW-1:0]   start_addr,
  input  logic [AW:0]     count,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   raddr,
  input  logic [SIZE-1:0] read_data,
  output logic [SIZE-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state;
  logic [AW-1:0]   ptr;
  logic [AW:0]     remaining;
  logic            in_flight;
  logic            head_valid;
  logic            tail_valid;
  logic [SIZE-1:0] head_data;
  logic [SIZE-1:0] tail_data;
  logic            pop;
  logic            issue;
  logic            last_word;
  logic [1:0]      occupancy;

  assign raddr     = ptr;
  assign out_data  = head_data;
  assign out_valid = head_valid;
  assign pop       = head_valid & out_ready;

  // Words held or on their way after this cycle's pop; at most two may exist.
  assign occupancy = {1'b0, head_valid} + {1'b0, tail_valid}
                   + {1'b0, in_flight} - {1'b0, pop};
  assign issue     = (state == READ) && (occupancy < 2'd2);
  assign last_word = pop && !tail_valid && !in_flight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ptr       <= '0;
      remaining <= '0;
      in_flight <= 1'b0;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all registers
      // update from the same pre-edge values, regardless of statement order.
      done      <= 1'b0;
      in_flight <= issue;
      case (state)
        IDLE: begin
          if (start) begin
            if (count == '0) begin
              done <= 1'b1;
            end else begin
              state     <= READ;
              busy      <= 1'b1;
              ptr       <= ({1'b0, start_addr} >= DEPTH_W) ? '0 : start_addr;
              remaining <= (count > DEPTH_W) ? DEPTH_W : count;
            end
          end
        end
        READ: begin
          if (issue) begin
            ptr       <= (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
            remaining <= remaining - (AW+1)'(1);
            if (remaining == (AW+1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_word) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head register drives the stream; tail catches a word arriving while the
  // head is stalled, so a read already in flight is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset too, because out_data is a
      // direct view of the head and must read zero while in reset.
      head_valid <= 1'b0;
      tail_valid <= 1'b0;
      head_data  <= '0;
      tail_data  <= '0;
    end else if (pop) begin
      if (tail_valid) begin
        head_data  <= tail_data;
        tail_valid <= in_flight;
        if (in_flight) tail_data <= read_data;
      end else begin
        head_valid <= in_flight;
        if (in_flight) head_data <= read_data;
      end
    end else if (in_flight) begin
      if (!head_valid) begin
        head_data  <= read_data;
        head_valid <= 1'b1;
      end else begin
        tail_data  <= read_data;
        tail_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural registered-read RAM, scoreboard of
// expected stream words, and directed cycle-timing checks.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] start_addr;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic [2:0] raddr;
  logic [7:0] read_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  logic [7:0] mem [8];
  logic [7:0] sb [$];
  int         checks = 0;
  int         errors = 0;
  int         hs_count = 0;
  logic       prev_stall = 1'b0;

  ram_stream_reader #(.SIZE(8), .DEPTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .start_addr (start_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .read_data  (read_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[raddr];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream monitor: the head must always equal the oldest expected word.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("stall_valid", int'(out_valid), 1);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("sb_underflow", sb.size(), 1);
        end else begin
          check("out_data", int'(out_data), int'(sb[0]));
          if (out_ready) begin
            void'(sb.pop_front());
            hs_count++;
          end
        end
      end
      if (done) check("done_sb_empty", sb.size(), 0);
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic start_burst(input int addr, input int cnt);
    start_addr = 3'(addr);
    count      = 4'(cnt);
    start      = 1'b1;
    for (int i = 0; i < cnt && i < 8; i++) sb.push_back(mem[3'((addr + i) % 8)]);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input bit toggle);
    int n = 0;
    bit seen = 1'b0;
    bit stop = 1'b0;
    while (!stop) begin
      if (toggle) begin
        if (n >= 6 && n <= 10) out_ready = 1'b0;
        else if (n > 40)       out_ready = 1'b1;
        else                   out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
        stop = 1'b1;
      end else if (n >= 300) begin
        stop = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check(tag, int'(seen), 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_done"},      int'(done),      0);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_out_data"},  int'(out_data),  0);
    check({tag, "_raddr"},     int'(raddr),     0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'(16 + i);
    rst        = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    count      = '0;
    out_ready  = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst: exact cycle timing of busy, done and out_valid.
    start_burst(2, 4);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) check("t1_first_raddr", int'(raddr), 2);
      check("t1_busy",      int'(busy),      int'(c <= 6));
      check("t1_done",      int'(done),      int'(c == 7));
      check("t1_out_valid", int'(out_valid), int'(c >= 3 && c <= 6));
      @(posedge clk); #1;
    end
    check("t1_sb_empty", sb.size(), 0);

    // Address wrap from DEPTH-1 to 0.
    start_burst(6, 4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t2_raddr", int'(raddr), (6 + c) % 8);
      @(posedge clk); #1;
    end
    wait_done("t2_done_seen", 1'b0);
    check("t2_sb_empty", sb.size(), 0);

    // Full-depth burst under random backpressure with a 5-cycle stall.
    hs_count = 0;
    start_burst(0, 8);
    wait_done("t3_done_seen", 1'b1);
    check("t3_handshakes", hs_count, 8);
    check("t3_sb_empty", sb.size(), 0);

    // Zero-length command.
    start_burst(3, 0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("t4_done",      int'(done),      int'(c == 1));
      check("t4_busy",      int'(busy),      0);
      check("t4_out_valid", int'(out_valid), 0);
      @(posedge clk); #1;
    end

    // A second start during a burst must be ignored.
    hs_count = 0;
    start_burst(0, 5);
    @(posedge clk); #1;
    start_addr = 3'd5;
    count      = 4'd3;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5_done_seen", 1'b0);
    check("t5_handshakes", hs_count, 5);
    repeat (3) begin
      @(negedge clk);
      check("t5_idle_after", int'(busy), 0);
      @(posedge clk); #1;
    end

    // Reset while stalled with the FIFO full, then a clean burst.
    out_ready = 1'b0;
    start_burst(0, 8);
    repeat (5) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("t6_stalled_valid", int'(out_valid), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("t6_rst");
    sb.delete();
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    hs_count = 0;
    start_burst(0, 2);
    wait_done("t6_done_seen", 1'b0);
    check("t6_handshakes", hs_count, 2);
    check("final_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side streaming engine for the simple dual-port RAM. On a start command it walks a range of RAM addresses, absorbs the RAM's one-cycle registered read latency, and presents the words on a valid/ready output stream with full backpressure support. It sits on the RAM's read port and feeds downstream consumers such as display or compare logic, while the write port is driven elsewhere.

## Interface
- SIZE, 8: word width; must match the RAM's SIZE.
- DEPTH, 8: number of RAM entries; AW = $clog2(DEPTH).
- clk  in  1  single clock; all logic on posedge clk.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  command strobe; sampled only while busy=0.
- start_addr  in  AW  first address of the burst.
- count  in  AW+1  number of words to read, 0..DEPTH.
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle pulse at burst completion.
- raddr  out  AW  address to the RAM read port.
- read_data  in  SIZE  RAM read data; valid the cycle after raddr is presented.
- out_data  out  SIZE  stream data.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high.

## Operation
- States:
  - IDLE: wait for a command.
  - READ: issue RAM reads.
  - DRAIN: all reads issued; wait for the buffer to empty and the last word to be accepted.
- IDLE -> READ on start=1 when count > 0.
  - Latch the address pointer: start_addr, or 0 if start_addr >= DEPTH.
  - Latch remaining = min(count, DEPTH).
- start with count=0: stay IDLE and pulse done in the next cycle. No out_valid.
- start is ignored while busy=1.
- Issue rule in READ: a read is issued in a cycle when (buffered + in_flight − pop) < 2, where pop = out_valid & out_ready.
  - raddr is driven combinationally from the pointer.
  - On issue: the pointer increments, wrapping from DEPTH−1 to 0; remaining decrements; in_flight is set.
- Data path: in the cycle after an issue, read_data is written into a 2-entry output FIFO.
  - out_data/out_valid come from the FIFO head.
  - This guarantees no data is lost or duplicated under any out_ready pattern.
- READ -> DRAIN when the last read is issued.
- DRAIN -> IDLE after the handshake of the final word.
  - In the next cycle, done=1 and busy=0.
  - A new start is accepted in that same cycle.
- busy=1 in every cycle the FSM is in READ or DRAIN.
- The raddr value is don't-care when not issuing. It holds the pointer value.

## Timing
- Reset values (async assert): state IDLE, busy=0, done=0, out_valid=0, out_data=0, raddr=0, FIFO empty, in_flight=0.
- Reset asserted mid-burst:
  - The burst is abandoned immediately; no done pulse.
  - After release the block is IDLE.
- Start accepted at edge 0:
  - Cycle 1: first issue (raddr=start_addr).
  - Cycle 2: read_data valid.
  - Cycle 3: out_valid=1.
- With out_ready held high, one word per cycle, no bubbles.
  - Burst of N words: last handshake in cycle N+2, done in cycle N+3.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data is held stable and out_valid stays high.
  - Issuing stalls once buffered + in_flight = 2.
  - One cycle after out_ready returns high, throughput resumes at one word per cycle.
- Reads never target an address twice within a burst. With count=DEPTH, every entry is read exactly once.

## Test plan
- DEPTH=8, RAM[i]=0x10+i, start_addr=2, count=4, out_ready=1:
  - out_data 0x12,0x13,0x14,0x15 in cycles 3..6.
  - done in cycle 7; busy high cycles 1..6.
- Wrap: start_addr=6, count=4 -> raddr 6,7,0,1; out_data 0x16,0x17,0x10,0x11.
- Backpressure: count=8, out_ready toggling per a pseudo-random pattern, including a 5-cycle low stretch:
  - exactly 8 handshakes, values 0x10..0x17 in order;
  - out_data stable during stalls.
- count=0 -> done in the next cycle, out_valid never asserted, busy stays 0.
- start pulsed again mid-burst with different start_addr/count -> ignored; the original burst completes unchanged.
- rst asserted during a stalled burst (FIFO full) -> all outputs 0 immediately. A subsequent start_addr=0, count=2 yields 0x10,0x11 and done.
